aes_encrypt_core: RTL and testbench

Iterative AES-128 encryption core, the forward-direction counterpart of the team's decryption core. It takes a 128-bit key and a 128-bit plaintext and produces the FIPS-197 ciphertext. It uses one S-box bank for all 16 bytes, a MixColumns unit that processes one column per cycle, and a round key computed on the fly, so no key schedule is stored. It sits behind the same START/DONE level handshake as the decryptor, so software drivers and the Avalon wrapper can use either core.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_key_step.sv | 26 ++
 rtl/aes_encrypt_core.sv | 105 ++++++++++
 tb/tb_aes_encrypt_core.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constants and the byte/column transforms
// used by both the encrypt and decrypt datapaths.
package aes_pkg;

   typedef enum logic [2:0] {StIdle, StSub, StShift, StMix, StArk, StDone} aes_state_e;

   localparam logic [3:0] LastRound = 4'd10;

   localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{8'd255 - b, 3'd0} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Row 0 is the most significant byte of the column.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
      return o;
   endfunction

   // Byte (row r, column c) lives at [127-8(4c+r) -: 8]; row r rotates left by r.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key expansion: derives the next round key from the current one.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] rk_i,
   input  logic [7:0]   rcon_i,
   output logic [127:0] rk_o
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] sub_rot;
   logic [31:0] n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = rk_i;

   // SubWord(RotWord(w3))
   assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

   assign n0 = w0 ^ sub_rot ^ {rcon_i, 24'h0};
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign rk_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor with on-the-fly key expansion and a one-column-per-cycle
// MixColumns, behind a START/DONE level handshake.
module aes_encrypt_core
   import aes_pkg::*;
(
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         AES_START,
   input  logic [127:0] AES_KEY,
   input  logic [127:0] AES_MSG_PT,
   output logic         AES_DONE,
   output logic [127:0] AES_MSG_ENC
);

   aes_state_e   fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rk_q, rk_d;
   logic [3:0]   round_q, round_d;
   logic [1:0]   col_q, col_d;
   logic [127:0] enc_q, enc_d;
   logic         done_q;
   logic [3:0]   rcon_idx;
   logic [127:0] rk_next;

   assign rcon_idx = (round_q >= 4'd1 && round_q <= LastRound) ? round_q - 4'd1 : 4'd0;

   aes_key_step u_key_step (
      .rk_i   (rk_q),
      .rcon_i (RCON[rcon_idx]),
      .rk_o   (rk_next)
   );

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rk_d    = rk_q;
      round_d = round_q;
      col_d   = col_q;
      enc_d   = enc_q;
      unique case (fsm_q)
         StIdle: begin
            if (AES_START) begin
               state_d = AES_MSG_PT ^ AES_KEY;
               rk_d    = AES_KEY;
               round_d = 4'd1;
               fsm_d   = StSub;
            end
         end
         StSub: begin
            state_d = sub_bytes(state_q);
            rk_d    = rk_next;
            fsm_d   = StShift;
         end
         StShift: begin
            state_d = shift_rows(state_q);
            col_d   = 2'd0;
            fsm_d   = (round_q < LastRound) ? StMix : StArk;
         end
         StMix: begin
            // Column c occupies bits [127-32c -: 32], i.e. base offset 32*(3-c).
            state_d[{~col_q, 5'd0} +: 32] = mix_column(state_q[{~col_q, 5'd0} +: 32]);
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) fsm_d = StArk;
         end
         StArk: begin
            state_d = state_q ^ rk_q;
            if (round_q == LastRound) begin
               enc_d = state_q ^ rk_q;
               fsm_d = StDone;
            end else begin
               round_d = round_q + 4'd1;
               fsm_d   = StSub;
            end
         end
         StDone: begin
            if (!AES_START) fsm_d = StIdle;
         end
         default: fsm_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         fsm_q   <= StIdle;
         state_q <= '0;
         rk_q    <= '0;
         round_q <= '0;
         col_q   <= '0;
         enc_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rk_q    <= rk_d;
         round_q <= round_d;
         col_q   <= col_d;
         enc_q   <= enc_d;
         done_q  <= (fsm_d == StDone);
      end
   end

   assign AES_DONE    = done_q;
   assign AES_MSG_ENC = enc_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core: FIPS vectors, random vectors against a GF(2^8)
// reference model, and handshake/reset corner cases.
module tb_aes_encrypt_core;

   localparam int Period = 10;

   logic         CLK;
   logic         RESET_N;
   logic         AES_START;
   logic [127:0] AES_KEY;
   logic [127:0] AES_MSG_PT;
   logic         AES_DONE;
   logic [127:0] AES_MSG_ENC;

   int  vectors = 0;
   int  miscompares = 0;
   time done_time = 0;
   time t1;

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   vec_t tbl [3];
   logic [7:0] sb [256];

   aes_encrypt_core dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .AES_START   (AES_START),
      .AES_KEY     (AES_KEY),
      .AES_MSG_PT  (AES_MSG_PT),
      .AES_DONE    (AES_DONE),
      .AES_MSG_ENC (AES_MSG_ENC)
   );

   initial begin
      CLK = 1'b0;
      forever #(Period / 2) CLK = ~CLK;
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   st [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c + r] = st[4*((c + r) % 4) + r];
         for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
               if (rnd < 10)
                  st[4*c + r] = gmul(8'h02, t[4*c + r]) ^ gmul(8'h03, t[4*c + (r+1)%4])
                                ^ t[4*c + (r+2)%4] ^ t[4*c + (r+3)%4];
               else
                  st[4*c + r] = t[4*c + r];
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = st[i];
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Called just after a falling edge; the next rising edge is E0.
   task automatic run_op(input logic [127:0] key, input logic [127:0] pt,
                         input logic [127:0] exp, input string tag, input int drop_at,
                         input int chg_at, input int hold, input bit peek);
      int lat;
      bit seen;
      bit held_ok;
      AES_KEY    = key;
      AES_MSG_PT = pt;
      AES_START  = 1'b1;
      lat  = -1;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (AES_DONE) begin
            seen      = 1'b1;
            lat       = k;
            done_time = $time;
         end
         if (k == drop_at) AES_START = 1'b0;
         if (k == chg_at) begin
            AES_KEY    = rand128();
            AES_MSG_PT = rand128();
         end
         if (peek && k == 7) begin
            chk({tag, " rk1"}, dut.rk_q, 128'ha0fafe1788542cb123a339392a6c7605);
            chk({tag, " round1 state"}, dut.state_q, 128'ha49c7ff2689f352b6b5bea43026a5049);
         end
      end
      chk({tag, " done edge"}, 128'(lat), 128'd66);
      chk({tag, " ciphertext"}, AES_MSG_ENC, exp);
      if (hold > 0) begin
         held_ok = 1'b1;
         for (int k = 0; k < hold; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (AES_DONE !== 1'b1 || AES_MSG_ENC !== exp) held_ok = 1'b0;
         end
         chk({tag, " done held"}, 128'(held_ok), 128'd1);
         // Asynchronous reset while DONE is showing.
         #2 RESET_N = 1'b0;
         #1;
         chk({tag, " reset done"}, 128'(AES_DONE), 128'd0);
         chk({tag, " reset enc"}, AES_MSG_ENC, 128'd0);
         AES_START = 1'b0;
         #1 RESET_N = 1'b1;
      end
      AES_START = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk({tag, " done drop"}, 128'(AES_DONE), 128'd0);
   endtask

   logic [127:0] k0, p0, k1, p1;

   initial begin
      RESET_N    = 1'b0;
      AES_START  = 1'b0;
      AES_KEY    = '0;
      AES_MSG_PT = '0;
      build_sbox();

      tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                 128'h3925841d02dc09fbdc118597196a0b32};
      tbl[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

      #1;
      chk("reset AES_DONE", 128'(AES_DONE), 128'd0);
      chk("reset AES_MSG_ENC", AES_MSG_ENC, 128'd0);
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;

      for (int i = 0; i < 3; i++) begin
         run_op(tbl[i].key, tbl[i].pt, tbl[i].ct, $sformatf("fips%0d", i), -1, -1, 0, i == 1);
      end

      // START held for 100 cycles from E0
      k0 = rand128();
      p0 = rand128();
      run_op(k0, p0, aes_ref(k0, p0), "hold", -1, -1, 34, 1'b0);

      // START dropped mid-run
      k0 = rand128();
      p0 = rand128();
      run_op(k0, p0, aes_ref(k0, p0), "drop10", 10, -1, 0, 1'b0);

      // Reset between edges at cycle 30 of a run
      AES_KEY    = tbl[0].key;
      AES_MSG_PT = tbl[0].pt;
      AES_START  = 1'b1;
      repeat (31) @(posedge CLK);
      #2 RESET_N = 1'b0;
      #1;
      chk("midrun reset AES_DONE", 128'(AES_DONE), 128'd0);
      chk("midrun reset AES_MSG_ENC", AES_MSG_ENC, 128'd0);
      chk("midrun reset round", 128'(dut.round_q), 128'd0);
      AES_START = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
      run_op(tbl[0].key, tbl[0].pt, tbl[0].ct, "after reset", -1, -1, 0, 1'b0);

      // Inputs changed at cycle 5, then back-to-back with a 1-cycle START gap
      k0 = rand128();
      p0 = rand128();
      run_op(k0, p0, aes_ref(k0, p0), "input change", -1, 5, 0, 1'b0);
      t1 = done_time;
      k1 = rand128();
      p1 = rand128();
      run_op(k1, p1, aes_ref(k1, p1), "back2back", -1, -1, 0, 1'b0);
      chk("back2back period", 128'(done_time - t1), 128'(68 * Period));

      for (int i = 0; i < 6; i++) begin
         k0 = rand128();
         p0 = rand128();
         run_op(k0, p0, aes_ref(k0, p0), $sformatf("rand%0d", i), -1, -1, 0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
